// File: rtl/spi_master_if.sv
// Host-side and SPI-side signals of spi_master.
// The master modport is the block's own view; slave is the peer's view.
interface spi_master_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] tx_byte;
    logic       busy;
    logic       done;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start,
        input  cmd,
        input  tx_byte,
        input  MISO,
        output busy,
        output done,
        output rx_byte,
        output rx_valid,
        output SS_n,
        output MOSI
    );

    modport slave (
        output start,
        output cmd,
        output tx_byte,
        output MISO,
        input  busy,
        input  done,
        input  rx_byte,
        input  rx_valid,
        input  SS_n,
        input  MOSI
    );
endinterface

// File: rtl/spi_master.sv
// SPI master: shifts out one 10-bit {cmd, payload} frame per accepted start;
// read-data frames then clock one byte in from MISO after RD_WAIT turnaround cycles.
//
// state   | meaning
// S_IDLE  | slave deselected, waiting for start
// S_SHIFT | 10 cycles driving frame[9] .. frame[0] on MOSI
// S_WAIT  | RD_WAIT turnaround cycles before reading (cmd 11 only)
// S_READ  | 8 cycles sampling MISO, MSB first
// S_END   | one cycle: done pulse, rx_valid/rx_byte for cmd 11
module spi_master #(
    parameter int RD_WAIT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_READ,
        S_END
    } state_t;

    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam logic [3:0] SHIFT_LOAD  = 4'd9;
    localparam logic [3:0] READ_LOAD   = 4'd7;
    localparam logic [3:0] WAIT_LOAD   = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [9:0] frame, frame_nxt;
    logic [6:0] rx_shift, rx_shift_nxt;
    logic [7:0] rx_byte_q, rx_byte_nxt;
    logic       ss_n_q, ss_n_nxt;
    logic       mosi_q, mosi_nxt;
    logic       busy_q, busy_nxt;
    logic       done_q, done_nxt;
    logic       rx_valid_q, rx_valid_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            frame      <= '0;
            rx_shift   <= '0;
            rx_byte_q  <= '0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            frame      <= frame_nxt;
            rx_shift   <= rx_shift_nxt;
            rx_byte_q  <= rx_byte_nxt;
            ss_n_q     <= ss_n_nxt;
            mosi_q     <= mosi_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            rx_valid_q <= rx_valid_nxt;
        end
    end

    // Output values are computed for the state being entered, so every
    // output comes straight from a flop and lines up with the state register.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        frame_nxt    = frame;
        rx_shift_nxt = rx_shift;
        rx_byte_nxt  = rx_byte_q;
        ss_n_nxt     = 1'b1;
        mosi_nxt     = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        rx_valid_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_SHIFT;
                    frame_nxt = {bus.cmd, bus.tx_byte};
                    cnt_nxt   = SHIFT_LOAD;
                    ss_n_nxt  = 1'b0;
                    mosi_nxt  = bus.cmd[1];
                    busy_nxt  = 1'b1;
                end
            end

            S_SHIFT: begin
                busy_nxt = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_nxt  = cnt - 4'd1;
                    ss_n_nxt = 1'b0;
                    mosi_nxt = frame[cnt - 4'd1];
                end else if (frame[9:8] == CMD_RD_DATA) begin
                    ss_n_nxt = 1'b0;
                    if (RD_WAIT == 0) begin
                        state_nxt = S_READ;
                        cnt_nxt   = READ_LOAD;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end
                end else begin
                    state_nxt = S_END;
                    done_nxt  = 1'b1;
                end
            end

            S_WAIT: begin
                busy_nxt = 1'b1;
                ss_n_nxt = 1'b0;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = S_READ;
                    cnt_nxt   = READ_LOAD;
                end
            end

            S_READ: begin
                busy_nxt     = 1'b1;
                rx_shift_nxt = {rx_shift[5:0], bus.MISO};
                if (cnt != 4'd0) begin
                    cnt_nxt  = cnt - 4'd1;
                    ss_n_nxt = 1'b0;
                end else begin
                    state_nxt    = S_END;
                    done_nxt     = 1'b1;
                    rx_valid_nxt = 1'b1;
                    rx_byte_nxt  = {rx_shift, bus.MISO};
                end
            end

            S_END: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.SS_n     = ss_n_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_byte  = rx_byte_q;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: per-cycle frame expectations built from the frame
// format, with a small register-file slave model supplying read data.
module tb_spi_master;
    localparam int RD_WAIT = 2;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [7:0] exp_rx;
    logic [7:0] mem [256];
    logic [7:0] slave_addr;

    spi_master_if bus ();

    spi_master #(.RD_WAIT(RD_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete frame from the IDLE cycle through END; outputs are checked
    // mid-cycle, MISO is driven mid-cycle for sampling at the next rising edge.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input bit hold_start);
        logic [9:0] fr;
        logic [7:0] sbyte;
        int         total;
        int         rd_first;
        fr       = {c, d};
        sbyte    = mem[slave_addr];
        rd_first = 10 + RD_WAIT;
        total    = (c == 2'b11) ? rd_first + 8 : 10;

        @(negedge clk);
        chk("idle_ss_n", 8'(bus.SS_n), 8'd1);
        chk("idle_busy", 8'(bus.busy), 8'd0);
        chk("idle_done", 8'(bus.done), 8'd0);
        bus.start   = 1'b1;
        bus.cmd     = c;
        bus.tx_byte = d;
        @(posedge clk);
        #1;
        bus.cmd     = 2'($urandom);
        bus.tx_byte = 8'($urandom);
        if (!hold_start) bus.start = 1'b0;

        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            chk("frame_ss_n", 8'(bus.SS_n), 8'd0);
            chk("frame_busy", 8'(bus.busy), 8'd1);
            chk("frame_done", 8'(bus.done), 8'd0);
            chk("frame_rx_valid", 8'(bus.rx_valid), 8'd0);
            chk("frame_rx_hold", bus.rx_byte, exp_rx);
            chk("frame_mosi", 8'(bus.MOSI), (k < 10) ? 8'(fr[9 - k]) : 8'd0);
            if (c == 2'b11 && k >= rd_first)
                bus.MISO = sbyte[7 - (k - rd_first)];
            else
                bus.MISO = 1'($urandom);
            if (!hold_start) bus.start = 1'($urandom);
            bus.cmd     = 2'($urandom);
            bus.tx_byte = 8'($urandom);
        end

        case (c)
            2'b00: slave_addr = d;
            2'b01: mem[slave_addr] = d;
            2'b10: slave_addr = d;
            default: exp_rx = sbyte;
        endcase

        @(negedge clk);
        chk("end_ss_n", 8'(bus.SS_n), 8'd1);
        chk("end_mosi", 8'(bus.MOSI), 8'd0);
        chk("end_busy", 8'(bus.busy), 8'd1);
        chk("end_done", 8'(bus.done), 8'd1);
        chk("end_rx_valid", 8'(bus.rx_valid), (c == 2'b11) ? 8'd1 : 8'd0);
        chk("end_rx_byte", bus.rx_byte, exp_rx);
        bus.start = hold_start;
    endtask

    initial begin
        logic [1:0] c;
        logic [7:0] d;
        bit         hold;
        int         abort_at;

        n_vec      = 0;
        n_err      = 0;
        exp_rx     = 8'h00;
        slave_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.cmd     = 2'b00;
        bus.tx_byte = 8'h00;
        bus.MISO    = 1'b0;

        // Reset held with random activity on every input.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("rst_ss_n", 8'(bus.SS_n), 8'd1);
            chk("rst_mosi", 8'(bus.MOSI), 8'd0);
            chk("rst_busy", 8'(bus.busy), 8'd0);
            chk("rst_done", 8'(bus.done), 8'd0);
            chk("rst_rx_valid", 8'(bus.rx_valid), 8'd0);
            chk("rst_rx_byte", bus.rx_byte, 8'h00);
            bus.start   = 1'($urandom);
            bus.cmd     = 2'($urandom);
            bus.tx_byte = 8'($urandom);
            bus.MISO    = 1'($urandom);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst_n     = 1'b1;

        // Directed: write-address A5, write-data 3C, read-data of A5 -> 3C.
        run_frame(2'b00, 8'hA5, 1'b0);
        run_frame(2'b01, 8'h3C, 1'b0);
        run_frame(2'b11, 8'($urandom), 1'b0);
        chk("directed_read_3c", bus.rx_byte, 8'h3C);

        // Back-to-back sequence with start held high between frames.
        run_frame(2'b00, 8'hA5, 1'b1);
        run_frame(2'b01, 8'h3C, 1'b1);
        run_frame(2'b10, 8'hA5, 1'b1);
        run_frame(2'b11, 8'($urandom), 1'b0);
        chk("sequence_read_3c", bus.rx_byte, 8'h3C);

        // Write-data frame with start toggling randomly throughout.
        run_frame(2'b01, 8'($urandom), 1'b0);

        for (int i = 0; i < 24; i++) begin
            c    = 2'($urandom_range(0, 3));
            d    = 8'($urandom);
            hold = (i != 23) && ($urandom_range(0, 1) == 1);
            run_frame(c, d, hold);
        end

        // Abort a read frame in its fifth READ cycle.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.cmd     = 2'b11;
        bus.tx_byte = 8'($urandom);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        abort_at  = 10 + RD_WAIT + 4;
        for (int k = 0; k <= abort_at; k++) begin
            @(negedge clk);
            bus.MISO = 1'($urandom);
        end
        rst_n  = 1'b0;
        exp_rx = 8'h00;
        #1;
        chk("abort_ss_n", 8'(bus.SS_n), 8'd1);
        chk("abort_mosi", 8'(bus.MOSI), 8'd0);
        chk("abort_busy", 8'(bus.busy), 8'd0);
        chk("abort_done", 8'(bus.done), 8'd0);
        chk("abort_rx_valid", 8'(bus.rx_valid), 8'd0);
        chk("abort_rx_byte", bus.rx_byte, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold_done", 8'(bus.done), 8'd0);
            chk("abort_hold_ss_n", 8'(bus.SS_n), 8'd1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First rising edge after release sees start high.
        run_frame(2'b11, 8'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) begin
            c = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            run_frame(c, d, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL expose parameter RD_WAIT, default 2, giving the number of turnaround cycles between the last MOSI bit and the first MISO sample of a read-data frame (legal range 0..15).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to send one frame; sampled only in IDLE.
REQ-005 cmd  input  2  frame command: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-006 tx_byte  input  8  frame payload (address or data; don't-care for cmd 11).
REQ-007 busy  output  1  high from the cycle after start is accepted until the END cycle inclusive.
REQ-008 done  output  1  one-cycle pulse marking frame completion.
REQ-009 rx_byte  output  8  last byte received on MISO; holds its value between reads.
REQ-010 rx_valid  output  1  one-cycle pulse, coincident with done, only for cmd 11 frames.
REQ-011 SS_n  output  1  slave select to the SPI slave, active-low.
REQ-012 MOSI  output  1  serial data to the slave, MSB first.
REQ-013 MISO  input  1  serial data from the slave, MSB first.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT, WAIT, READ and END; all outputs SHALL be registered.
REQ-015 IDLE: SS_n=1, MOSI=0, busy=0; start=1 at a rising edge SHALL latch frame={cmd,tx_byte} (10 bits) and enter SHIFT.
REQ-016 SHIFT: lasts exactly 10 cycles, SS_n=0, MOSI=frame[9] in the first cycle down to frame[0] in the tenth.
REQ-017 After SHIFT: cmd 00/01/10 SHALL go to END; cmd 11 SHALL go to WAIT (or directly to READ if RD_WAIT=0).
REQ-018 WAIT: lasts RD_WAIT cycles, SS_n=0, MOSI=0.
REQ-019 READ: lasts exactly 8 cycles, SS_n=0, MOSI=0; MISO SHALL be sampled at the rising edge ending each READ cycle and shifted into an 8-bit register MSB first.
REQ-020 END: lasts one cycle, SS_n=1, MOSI=0, busy=1, done=1; for cmd 11, rx_byte SHALL update to the shifted byte and rx_valid=1 in this cycle; the next state SHALL be IDLE.
REQ-021 SS_n low duration SHALL be exactly 10 cycles for cmd 00/01/10 and exactly 18+RD_WAIT cycles for cmd 11.
REQ-022 start asserted in any state other than IDLE SHALL be ignored, not queued.
REQ-023 Changes to cmd/tx_byte after acceptance SHALL NOT affect the frame in flight.
REQ-024 Minimum SS_n-high gap between back-to-back frames (start held high) SHALL be 2 cycles (END + IDLE).
REQ-025 rx_byte SHALL NOT change on cmd 00/01/10 frames.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rx_valid=0, rx_byte=8'h00, frame register 0.
REQ-027 Reset during any non-IDLE state SHALL abort the frame with no done or rx_valid pulse; after release the block SHALL accept a new start normally.
REQ-028 On the first rising edge after rst_n goes high, start SHALL be honoured if high.

Verification
REQ-029 Reset: hold rst_n=0 for 1000 cycles with random start/cmd/tx_byte/MISO -> SS_n=1, MOSI=0, busy=0, done=0, rx_byte=00 throughout.
REQ-030 Write-address: cmd=00, tx_byte=A5 -> MOSI=0,0,1,0,1,0,0,1,0,1 over 10 SS_n-low cycles, done high in the following cycle, rx_valid=0.
REQ-031 Read-data: cmd=11, RD_WAIT=2, slave model driving 3C MSB first during READ -> SS_n low 20 cycles, rx_byte=3C with rx_valid=done=1 in END.
REQ-032 Full sequence against spi_wrapper: write-address A5, write-data 3C, read-address A5, read-data -> rx_byte=3C, four done pulses, SS_n high >=2 cycles between frames.
REQ-033 start pulsed during SHIFT of a cmd 01 frame -> ignored; exactly one done pulse; busy stays high throughout.
REQ-034 rst_n dropped in cycle 5 of READ -> SS_n=1 asynchronously, no done/rx_valid, rx_byte=00; next cmd 11 frame completes with correct data.
